qam16_symbol_mapper: RTL and testbench



---
 rtl/qam_pkg.sv | 45 ++++
 rtl/qam16_gray_map.sv | 19 +
 rtl/qam16_symbol_mapper.sv | 147 ++++++++++++++
 tb/tb_qam16_symbol_mapper.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/qam_pkg.sv
// Shared 16-QAM transmit definitions: baud codes, symbol period lookup and Gray amplitude levels.
package qam_pkg;

  localparam int SAMPLE_W = 32;

  typedef enum logic [1:0] {
    BAUD_2400  = 2'b00,
    BAUD_4800  = 2'b01,
    BAUD_9600  = 2'b10,
    BAUD_19200 = 2'b11
  } baud_e;

  // Symbol period in 76.8 kHz clock cycles.
  function automatic logic [5:0] period_of(baud_e b);
    case (b)
      BAUD_4800:  period_of = 6'd16;
      BAUD_9600:  period_of = 6'd8;
      BAUD_19200: period_of = 6'd4;
      default:    period_of = 6'd32;
    endcase
  endfunction

  function automatic logic [4:0] last_phase(baud_e b);
    logic [5:0] p;
    p = period_of(b) - 6'd1;
    return p[4:0];
  endfunction

  // Last phase of the stuff window (quarter period) that still carries the symbol value.
  function automatic logic [4:0] stuff_last(baud_e b);
    logic [5:0] p;
    p = (period_of(b) >> 2) - 6'd1;
    return p[4:0];
  endfunction

  function automatic int gray_level(logic [1:0] g);
    case (g)
      2'b00:   gray_level = -3;
      2'b01:   gray_level = -1;
      2'b11:   gray_level = 1;
      default: gray_level = 3;
    endcase
  endfunction

endpackage

// File: rtl/qam16_gray_map.sv
// Combinational 16-QAM Gray mapper: I from code[3:2], Q from code[1:0], levels {-3,-1,+1,+3} * AMP.
// Zero latency, no flow control; shared with the receiver slicer model.
module qam16_gray_map
  import qam_pkg::*;
#(
  parameter int OUT_W = SAMPLE_W,
  parameter int AMP   = 8192
) (
  input  logic [3:0]       code,
  output logic [OUT_W-1:0] lvl_i,
  output logic [OUT_W-1:0] lvl_q
);

  always_comb begin
    lvl_i = OUT_W'(gray_level(code[3:2]) * AMP);
    lvl_q = OUT_W'(gray_level(code[1:0]) * AMP);
  end

endmodule

// File: rtl/qam16_symbol_mapper.sv
// Packs a serial bit stream into 16-QAM symbols paced at the selected baud; output one cycle after the boundary.
// bit_ready drops while a full nibble waits behind an occupied hold register; enable low flushes everything.
module qam16_symbol_mapper
  import qam_pkg::*;
#(
  parameter int OUT_W      = SAMPLE_W,
  parameter int AMP        = 8192,
  parameter int ZERO_STUFF = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [1:0]       baud_rate,
  input  logic             bit_in,
  input  logic             bit_valid,
  output logic             bit_ready,
  output logic [OUT_W-1:0] sym_i,
  output logic [OUT_W-1:0] sym_q,
  output logic             sym_strobe,
  output logic             underflow
);

  logic [4:0]       phase_q, phase_d;
  baud_e            baud_q, baud_d;
  logic [3:0]       sr_q, sr_d;
  logic [2:0]       cnt_q, cnt_d;
  logic [3:0]       hold_q, hold_d;
  logic             hold_vld_q, hold_vld_d;
  logic             started_q, started_d;
  logic [OUT_W-1:0] sym_i_q, sym_i_d;
  logic [OUT_W-1:0] sym_q_q, sym_q_d;
  logic             strobe_q, strobe_d;
  logic             underflow_q, underflow_d;

  logic [OUT_W-1:0] map_i, map_q;
  logic             boundary, transfer, accept;

  qam16_gray_map #(
    .OUT_W (OUT_W),
    .AMP   (AMP)
  ) u_gray_map (
    .code  (hold_q),
    .lvl_i (map_i),
    .lvl_q (map_q)
  );

  always_comb begin
    boundary  = enable && (phase_q == last_phase(baud_q));
    transfer  = (cnt_q == 3'd4) && (!hold_vld_q || boundary);
    bit_ready = enable && ((cnt_q != 3'd4) || transfer);
    accept    = bit_valid && bit_ready;

    phase_d     = phase_q;
    baud_d      = baud_q;
    sr_d        = sr_q;
    cnt_d       = cnt_q;
    hold_d      = hold_q;
    hold_vld_d  = hold_vld_q;
    started_d   = started_q;
    sym_i_d     = sym_i_q;
    sym_q_d     = sym_q_q;
    strobe_d    = 1'b0;
    underflow_d = 1'b0;

    if (!enable) begin
      phase_d    = '0;
      baud_d     = baud_e'(baud_rate);
      cnt_d      = '0;
      hold_vld_d = 1'b0;
      started_d  = 1'b0;
      sym_i_d    = '0;
      sym_q_d    = '0;
    end else begin
      phase_d = boundary ? 5'd0 : phase_q + 5'd1;
      if (boundary) begin
        baud_d = baud_e'(baud_rate);
      end

      if (accept) begin
        sr_d = {sr_q[2:0], bit_in};
      end
      if (transfer) begin
        hold_d = sr_q;
        cnt_d  = accept ? 3'd1 : 3'd0;
      end else if (accept) begin
        cnt_d = cnt_q + 3'd1;
      end

      if (transfer) begin
        hold_vld_d = 1'b1;
      end else if (boundary) begin
        hold_vld_d = 1'b0;
      end

      // The mapper reads the old hold value; a same-cycle transfer only refills it.
      if (boundary) begin
        if (hold_vld_q) begin
          sym_i_d   = map_i;
          sym_q_d   = map_q;
          strobe_d  = 1'b1;
          started_d = 1'b1;
        end else begin
          sym_i_d     = '0;
          sym_q_d     = '0;
          underflow_d = started_q;
        end
      end else if ((ZERO_STUFF != 0) && (phase_q == stuff_last(baud_q))) begin
        sym_i_d = '0;
        sym_q_d = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      phase_q     <= '0;
      baud_q      <= BAUD_2400;
      sr_q        <= '0;
      cnt_q       <= '0;
      hold_q      <= '0;
      hold_vld_q  <= 1'b0;
      started_q   <= 1'b0;
      sym_i_q     <= '0;
      sym_q_q     <= '0;
      strobe_q    <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      phase_q     <= phase_d;
      baud_q      <= baud_d;
      sr_q        <= sr_d;
      cnt_q       <= cnt_d;
      hold_q      <= hold_d;
      hold_vld_q  <= hold_vld_d;
      started_q   <= started_d;
      sym_i_q     <= sym_i_d;
      sym_q_q     <= sym_q_d;
      strobe_q    <= strobe_d;
      underflow_q <= underflow_d;
    end
  end

  assign sym_i      = sym_i_q;
  assign sym_q      = sym_q_q;
  assign sym_strobe = strobe_q;
  assign underflow  = underflow_q;

endmodule

// File: tb/tb_qam16_symbol_mapper.sv
// Bench for qam16_symbol_mapper: zero-stuffed and held-output instances share one stimulus stream,
// checked every cycle against a queue-based model plus directed corner-case sequences.
module tb_qam16_symbol_mapper;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic [1:0]  baud_rate = 2'b00;
  logic        bit_in = 1'b0;
  logic        bit_valid = 1'b0;
  logic        bit_ready, sym_strobe, underflow;
  logic [31:0] sym_i, sym_q;
  logic        h_bit_ready, h_strobe, h_underflow;
  logic [31:0] h_sym_i, h_sym_q;

  qam16_symbol_mapper #(.OUT_W(32), .AMP(8192), .ZERO_STUFF(1)) dut (
    .clk(clk), .reset(reset), .enable(enable), .baud_rate(baud_rate),
    .bit_in(bit_in), .bit_valid(bit_valid), .bit_ready(bit_ready),
    .sym_i(sym_i), .sym_q(sym_q), .sym_strobe(sym_strobe), .underflow(underflow)
  );

  qam16_symbol_mapper #(.OUT_W(32), .AMP(8192), .ZERO_STUFF(0)) dut_hold (
    .clk(clk), .reset(reset), .enable(enable), .baud_rate(baud_rate),
    .bit_in(bit_in), .bit_valid(bit_valid), .bit_ready(h_bit_ready),
    .sym_i(h_sym_i), .sym_q(h_sym_q), .sym_strobe(h_strobe), .underflow(h_underflow)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  typedef struct {
    logic [3:0] code;
    int         exp_i;
    int         exp_q;
  } vec_t;
  vec_t tbl [16];

  // Stimulus bit queue, MSB of each symbol first.
  bit txq[$];
  bit vld_mask = 1'b1;

  // Reference model state.
  bit m_valid = 1'b0;
  int m_phase, m_baud, m_sym, m_age, m_stuff;
  int m_bits[$];
  int m_held[$];
  bit m_started, m_have, e_strobe, e_uf, m_rdy;

  task automatic chk(input string nm, input logic signed [63:0] act, input longint exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Gray pair -> amplitude: undo the Gray code, then map index 0..3 to -3,-1,+1,+3.
  function automatic int lvl(int g);
    int n;
    n = g ^ (g >> 1);
    return (2 * n - 3) * 8192;
  endfunction

  task automatic model_clear();
    m_phase = 0; m_bits.delete(); m_held.delete();
    m_started = 0; m_have = 0; e_strobe = 0; e_uf = 0;
  endtask

  task automatic compare_and_step(input bit rst, input bit en, input bit bv, input bit b,
                                  input logic [1:0] br);
    int p, hi, hq;
    bit bnd, xfer;
    p    = 32 >> m_baud;
    bnd  = en && (m_phase == p - 1);
    xfer = (m_bits.size() == 4) && (m_held.size() == 0 || bnd);
    m_rdy = en && (m_bits.size() < 4 || xfer);
    if (m_valid) begin
      hi = m_have ? lvl(m_sym >> 2) : 0;
      hq = m_have ? lvl(m_sym & 3) : 0;
      chk("bit_ready", bit_ready, m_rdy);
      chk("sym_i", $signed(sym_i), (m_age <= m_stuff) ? hi : 0);
      chk("sym_q", $signed(sym_q), (m_age <= m_stuff) ? hq : 0);
      chk("sym_strobe", sym_strobe, e_strobe);
      chk("underflow", underflow, e_uf);
      chk("hold_sym_i", $signed(h_sym_i), hi);
      chk("hold_sym_q", $signed(h_sym_q), hq);
      chk("hold_strobe", h_strobe, e_strobe);
      chk("hold_underflow", h_underflow, e_uf);
    end
    if (rst) begin
      model_clear();
      m_baud = 0;
      m_valid = 1'b1;
    end else if (!en) begin
      model_clear();
      m_baud = int'(br);
    end else begin
      e_strobe = 0;
      e_uf = 0;
      if (bnd) begin
        if (m_held.size() > 0) begin
          m_sym = m_held.pop_front();
          m_have = 1; m_age = 1; e_strobe = 1; m_started = 1;
        end else begin
          m_have = 0;
          e_uf = m_started;
        end
        m_baud  = int'(br);
        m_phase = 0;
        m_stuff = (32 >> m_baud) / 4;
      end else begin
        m_phase++;
        m_age++;
      end
      if (xfer) begin
        m_held.push_back(m_bits[0] * 8 + m_bits[1] * 4 + m_bits[2] * 2 + m_bits[3]);
        m_bits.delete();
      end
      if (bv && m_rdy) m_bits.push_back(int'(b));
    end
  endtask

  task automatic tick(input bit rst_i, input bit en_i, input logic [1:0] br_i);
    @(posedge clk);
    #1;
    cyc++;
    reset     = rst_i;
    enable    = en_i;
    baud_rate = br_i;
    bit_valid = (txq.size() > 0) && vld_mask;
    bit_in    = (txq.size() > 0) ? txq[0] : 1'b0;
    @(negedge clk);
    compare_and_step(rst_i, en_i, bit_valid, bit_in, br_i);
    if (bit_valid && m_rdy) void'(txq.pop_front());
  endtask

  task automatic push_code(input logic [3:0] c);
    txq.push_back(c[3]); txq.push_back(c[2]); txq.push_back(c[1]); txq.push_back(c[0]);
  endtask

  // Reset, then one idle cycle so baud_q picks up the requested rate; cycle 0 is the next tick.
  task automatic do_reset(input logic [1:0] br);
    txq.delete();
    vld_mask = 1'b1;
    tick(1'b1, 1'b0, br);
    tick(1'b1, 1'b0, br);
    chk("rst_sym_i", sym_i, 0);
    chk("rst_sym_q", sym_q, 0);
    chk("rst_strobe", sym_strobe, 0);
    chk("rst_underflow", underflow, 0);
    chk("rst_hold_sym_i", h_sym_i, 0);
    chk("rst_hold_sym_q", h_sym_q, 0);
    tick(1'b0, 1'b0, br);
    cyc = -1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int k, last;
    logic [1:0] br;
    bit en, rs;

    tbl[0]  = '{4'h0, -24576, -24576};  tbl[1]  = '{4'h1, -24576, -8192};
    tbl[2]  = '{4'h2, -24576,  24576};  tbl[3]  = '{4'h3, -24576,  8192};
    tbl[4]  = '{4'h4,  -8192, -24576};  tbl[5]  = '{4'h5,  -8192, -8192};
    tbl[6]  = '{4'h6,  -8192,  24576};  tbl[7]  = '{4'h7,  -8192,  8192};
    tbl[8]  = '{4'h8,  24576, -24576};  tbl[9]  = '{4'h9,  24576, -8192};
    tbl[10] = '{4'hA,  24576,  24576};  tbl[11] = '{4'hB,  24576,  8192};
    tbl[12] = '{4'hC,   8192, -24576};  tbl[13] = '{4'hD,   8192, -8192};
    tbl[14] = '{4'hE,   8192,  24576};  tbl[15] = '{4'hF,   8192,  8192};

    // 19200 Bd: first symbol, silent first boundary, then an underflow slot and a resumed symbol.
    do_reset(2'b11);
    push_code(4'b1011);
    for (int c = 0; c < 21; c++) begin
      if (c == 12) push_code(4'b0101);
      tick(1'b0, 1'b1, 2'b11);
      if (c < 4) chk("t1_ready", bit_ready, 1);
      if (c == 4) begin chk("t1_silent_uf", underflow, 0); chk("t1_silent_stb", sym_strobe, 0); end
      if (c == 8) begin
        chk("t1_sym_i", $signed(sym_i), 24576);
        chk("t1_sym_q", $signed(sym_q), 8192);
        chk("t1_strobe", sym_strobe, 1);
      end
      if (c >= 9 && c <= 11) begin chk("t1_stuff_i", sym_i, 0); chk("t1_stuff_q", sym_q, 0); end
      if (c == 12) begin
        chk("t3_uf", underflow, 1); chk("t3_no_stb", sym_strobe, 0); chk("t3_zero", sym_i, 0);
      end
      if (c == 13) chk("t3_uf_once", underflow, 0);
      if (c == 20) begin
        chk("t3_resume_i", $signed(sym_i), -8192);
        chk("t3_resume_q", $signed(sym_q), -8192);
        chk("t3_resume_stb", sym_strobe, 1);
      end
    end

    // 2400 Bd: all 16 codes back to back against the Gray table, strobes 32 cycles apart.
    do_reset(2'b00);
    for (int i = 0; i < 16; i++) push_code(tbl[i].code);
    k = 0;
    last = 0;
    for (int c = 0; c < 700 && k < 16; c++) begin
      tick(1'b0, 1'b1, 2'b00);
      if (sym_strobe === 1'b1) begin
        chk("tbl_i", $signed(sym_i), tbl[k].exp_i);
        chk("tbl_q", $signed(sym_q), tbl[k].exp_q);
        if (k > 0) chk("tbl_period", cyc - last, 32);
        last = cyc;
        k++;
      end
    end
    chk("tbl_count", k, 16);

    // Baud 11 -> 00 mid-symbol: the current slot keeps P=4, the next one runs 32 cycles.
    do_reset(2'b11);
    push_code(4'b1010);
    push_code(4'b0110);
    for (int c = 0; c < 45; c++) begin
      tick(1'b0, 1'b1, (c >= 9) ? 2'b00 : 2'b11);
      if (c == 8) begin
        chk("bd_sym1_i", $signed(sym_i), 24576); chk("bd_sym1_q", $signed(sym_q), 24576);
      end
      if (c == 12) begin
        chk("bd_sym2_stb", sym_strobe, 1);
        chk("bd_sym2_i", $signed(sym_i), -8192); chk("bd_sym2_q", $signed(sym_q), 24576);
      end
      if (c == 19) chk("bd_stuff_last", $signed(sym_i), -8192);
      if (c == 20) chk("bd_stuff_zero", sym_i, 0);
      if (c == 43) chk("bd_no_early_uf", underflow, 0);
      if (c == 44) chk("bd_uf_at_32", underflow, 1);
    end

    // Enable dropped after two bits: partial nibble discarded, no underflow before the first symbol.
    do_reset(2'b11);
    txq.push_back(1'b1);
    txq.push_back(1'b1);
    for (int c = 0; c < 14; c++) begin
      if (c == 5) push_code(4'b0000);
      tick(1'b0, !(c >= 2 && c <= 4), 2'b11);
      if (c >= 2 && c <= 4) begin
        chk("en_ready_low", bit_ready, 0); chk("en_out_zero", sym_i, 0);
      end
      if (c == 9) chk("en_no_uf", underflow, 0);
      if (c == 13) begin
        chk("en_first_stb", sym_strobe, 1);
        chk("en_first_i", $signed(sym_i), -24576); chk("en_first_q", $signed(sym_q), -24576);
      end
    end

    // 9600 Bd, held output instance: 1111 held 8 cycles, then 0101.
    do_reset(2'b10);
    push_code(4'b1111);
    push_code(4'b0101);
    for (int c = 0; c < 17; c++) begin
      tick(1'b0, 1'b1, 2'b10);
      if (c >= 8 && c <= 15) begin
        chk("hold_i", $signed(h_sym_i), 8192); chk("hold_q", $signed(h_sym_q), 8192);
      end
      if (c == 10) chk("stuffed_zero", sym_i, 0);
      if (c == 16) begin
        chk("hold_next_i", $signed(h_sym_i), -8192); chk("hold_next_q", $signed(h_sym_q), -8192);
      end
    end

    // Random traffic; segment 0 is plain 2400 Bd with continuous valid bits.
    for (int seg = 0; seg < 4; seg++) begin
      br = (seg == 0) ? 2'b00 : 2'($urandom_range(0, 3));
      do_reset(br);
      last = -1;
      for (int c = 0; c < 700; c++) begin
        while (txq.size() < 8) txq.push_back(1'($urandom_range(0, 1)));
        en = 1'b1;
        rs = 1'b0;
        if (seg != 0) begin
          vld_mask = ($urandom_range(0, 3) != 0);
          if ($urandom_range(0, 39) == 0) br = 2'($urandom_range(0, 3));
          en = ($urandom_range(0, 99) != 0);
          rs = ($urandom_range(0, 499) == 0);
        end
        tick(rs, en, br);
        if (seg == 0 && sym_strobe === 1'b1) begin
          if (last >= 0) chk("rand_period", cyc - last, 32);
          last = cyc;
        end
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
